sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//   Time-shares the single 256Kx16 asynchronous SRAM between three requesters:
//   - the video fetch path (shifter)
//   - the CPU bus (bkcore)
//   - the JTAG host loader
//   Replaces the combinational address/OE/WE muxing at top level with one registered
//   access sequencer: fixed priority plus a host anti-starvation promotion, byte-lane
//   generation, read-data capture and per-requester ack pulses.
// PARAMETERS
//   ACC_CYC    2          clk25 cycles per SRAM access (min 2: 1 addr-setup + >=1 strobe)
//   VID_BASE   5'b00001   ram_addr[17:13] for video fetches (screen RAM window)
//   STARVE     8'd32      cycles host_req may wait before it is promoted above CPU
// PORTS
//   clk25       in   1   system clock; all state on rising edge
//   reset_in    in   1   asynchronous, active-high reset
//   vid_req     in   1   video fetch request, held until vid_ack
//   vid_addr    in   13  word address within the video window
//   vid_ack     out  1   1-cycle pulse; vid_data valid in the same cycle
//   vid_data    out  16  captured video word
//   cpu_req     in   1   CPU request, held until cpu_ack
//   cpu_we      in   1   1 = write, 0 = read
//   cpu_byte    in   1   1 = byte access
//   cpu_adr     in   16  byte address
//   cpu_wdata   in   16  write data; byte writes use bits [7:0]
//   cpu_ack     out  1   1-cycle completion pulse
//   cpu_rdata   out  16  captured read word (full word, even for byte reads)
//   host_req    in   1   host request, held until host_ack
//   host_we     in   1   1 = write, 0 = read
//   host_addr   in   18  word address (always full-word access)
//   host_wdata  in   16  write data
//   host_ack    out  1   1-cycle completion pulse
//   host_rdata  out  16  captured read word
//   ram_addr    out  18  SRAM word address
//   ram_dq_o    out  16  SRAM write data
//   ram_dq_oe   out  1   1 = drive ram_dq_o onto the bus
//   ram_dq_i    in   16  SRAM read data
//   ram_oe_n    out  1   SRAM output enable, active low
//   ram_we_n    out  1   SRAM write enable, active low
//   ram_lb_n    out  1   low byte lane enable, active low
//   ram_ub_n    out  1   high byte lane enable, active low
// BEHAVIOUR
//   Reset (async):
//   - state=IDLE; starvation counter=0.
//   - ram_oe_n/ram_we_n/ram_lb_n/ram_ub_n=1; ram_dq_oe=0; ram_addr=0; ram_dq_o=0.
//   - all acks=0; all rdata/vid_data=0.
//   - A reset asserted mid-access aborts the access immediately; no ack is issued.
//   Registered outputs; states IDLE, ACCESS. Arbitration is evaluated in IDLE, and also
//   on the final ACCESS cycle so that back-to-back accesses are possible.
//   Priority: vid > cpu > host; host > cpu when the starvation counter == STARVE.
//   - Video is never preempted by the host.
//   Starvation counter:
//   - Increments each cycle host_req=1 and is not granted; saturates at STARVE.
//   - Clears on a host grant or when host_req=0.
//   Grant at edge k -> ACCESS. ram_addr and lanes are valid for cycles k..k+ACC_CYC-1.
//   - Read: ram_oe_n=0 for all ACC_CYC cycles.
//   - Write: ram_dq_oe=1 for all ACC_CYC cycles; ram_we_n=0 for cycles k+1..k+ACC_CYC-1.
//   - ram_oe_n and ram_we_n are never both low.
//   - Edge k+ACC_CYC: reads latch ram_dq_i into the requester's rdata; that requester's
//     ack=1 for exactly one cycle. The next grant may take effect on the same edge.
//   Address mapping:
//   - vid: {VID_BASE, vid_addr}.
//   - cpu: {3'b000, cpu_adr[15:1]}.
//   - host: host_addr.
//   Lanes (cpu only):
//   - word access: lb_n=ub_n=0.
//   - byte, even address: lb_n=0, ub_n=1.
//   - byte, odd address: lb_n=1, ub_n=0.
//   - Byte writes drive ram_dq_o={cpu_wdata[7:0],cpu_wdata[7:0]}.
//   - vid and host accesses are always full word.
//   Inputs are sampled at the grant edge and held internally. If req drops before ack,
//   the access still completes and ack is still pulsed.
//   Idle bus: ram_oe_n=1, ram_we_n=1, ram_dq_oe=0, lanes=1, ram_addr holds its last value.
// TESTING
//   1. Reset mid-write (assert at cycle k+1) -> ram_we_n=1, ram_dq_oe=0 asynchronously;
//      no cpu_ack; after release, state is IDLE.
//   2. cpu read, cpu_adr=16'o001000, ram_dq_i=16'hA5C3 -> ram_addr=18'h00100, ram_oe_n=0
//      for 2 cycles, cpu_ack 2 cycles after grant, cpu_rdata=16'hA5C3.
//   3. cpu byte write, adr=16'h0401, wdata=16'h0077 -> ram_addr=18'h00200, lb_n=1,
//      ub_n=0, ram_dq_o=16'h7777, ram_we_n low 1 cycle, then cpu_ack.
//   4. vid_req and cpu_req rise on the same edge, vid_addr=13'h0005 -> video served first
//      (ram_addr=18'h02005); cpu granted on the vid_ack edge, with no idle cycle between.
//   5. host_req held while cpu_req is held continuously -> host is granted after
//      32 waiting cycles, ahead of the next CPU access; the counter then returns to 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - registered access sequencer sharing one async SRAM between video, CPU and host
//
// Purpose:
//   One registered sequencer owns the 256Kx16 asynchronous SRAM. Three requesters
//   (video fetch, CPU bus, JTAG host loader) compete for it. Fixed priority
//   vid > cpu > host, with the host promoted above the CPU once it has waited STARVE
//   cycles. Each grant runs ACC_CYC cycles, then pulses the requester's ack and,
//   for reads, captures the SRAM word.
//
// Ports:
//   i_clk25, i_reset_in         clock, asynchronous active-high reset
//   i_vid_*  / o_vid_*          video fetch request, 13-bit window address, ack, data
//   i_cpu_*  / o_cpu_*          CPU request, we, byte, byte address, wdata, ack, rdata
//   i_host_* / o_host_*         host request, we, 18-bit word address, wdata, ack, rdata
//   o_ram_*, i_ram_dq_i         SRAM address, data out/in, dq drive enable, OE/WE/LB/UB (active low)
module sram_arbiter #(
    parameter int         ACC_CYC  = 2,
    parameter logic [4:0] VID_BASE = 5'b00001,
    parameter logic [7:0] STARVE   = 8'd32
) (
    input  logic        i_clk25,
    input  logic        i_reset_in,
    input  logic        i_vid_req,
    input  logic [12:0] i_vid_addr,
    output logic        o_vid_ack,
    output logic [15:0] o_vid_data,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic        i_cpu_byte,
    input  logic [15:0] i_cpu_adr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [15:0] o_cpu_rdata,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [17:0] i_host_addr,
    input  logic [15:0] i_host_wdata,
    output logic        o_host_ack,
    output logic [15:0] o_host_rdata,
    output logic [17:0] o_ram_addr,
    output logic [15:0] o_ram_dq_o,
    output logic        o_ram_dq_oe,
    input  logic [15:0] i_ram_dq_i,
    output logic        o_ram_oe_n,
    output logic        o_ram_we_n,
    output logic        o_ram_lb_n,
    output logic        o_ram_ub_n
);

    localparam int CNT_W = $clog2(ACC_CYC);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_HOST} owner_t;

    state_t             r_state, w_state_nxt;
    owner_t             r_owner, w_owner_nxt;
    logic [CNT_W-1:0]   r_cyc, w_cyc_nxt;
    logic               r_we, w_we_nxt;
    logic [7:0]         r_starve, w_starve_nxt;
    logic [17:0]        r_ram_addr, w_ram_addr_nxt;
    logic [15:0]        r_ram_dq_o, w_ram_dq_o_nxt;
    logic               r_ram_dq_oe, w_ram_dq_oe_nxt;
    logic               r_ram_oe_n, w_ram_oe_n_nxt;
    logic               r_ram_we_n, w_ram_we_n_nxt;
    logic               r_ram_lb_n, w_ram_lb_n_nxt;
    logic               r_ram_ub_n, w_ram_ub_n_nxt;
    logic               r_vid_ack, w_vid_ack_nxt;
    logic               r_cpu_ack, w_cpu_ack_nxt;
    logic               r_host_ack, w_host_ack_nxt;
    logic [15:0]        r_vid_data, w_vid_data_nxt;
    logic [15:0]        r_cpu_rdata, w_cpu_rdata_nxt;
    logic [15:0]        r_host_rdata, w_host_rdata_nxt;

    logic               w_last, w_arb, w_promote;
    logic               w_vid_el, w_cpu_el, w_host_el;
    logic               w_gnt_vid, w_gnt_cpu, w_gnt_host, w_gnt;
    owner_t             w_sel_owner;
    logic [17:0]        w_sel_addr;
    logic               w_sel_we;
    logic [15:0]        w_sel_wdata;
    logic               w_sel_lb_n, w_sel_ub_n;

    // Arbitration happens in IDLE and on the final ACCESS cycle. On the final cycle
    // the current owner still holds its request (it only sees ack after this edge),
    // so it is masked to avoid serving it twice. An unpromoted host is also held off
    // on the final cycle: the bus idles one cycle so a CPU that re-requests after its
    // ack still outranks it; a promoted host takes the slot directly.
    assign w_last    = (r_state == S_ACCESS) && (r_cyc == CNT_W'(ACC_CYC - 1));
    assign w_arb     = (r_state == S_IDLE) || w_last;
    assign w_promote = (r_starve == STARVE);

    assign w_vid_el  = i_vid_req  && !(w_last && (r_owner == OWN_VID));
    assign w_cpu_el  = i_cpu_req  && !(w_last && (r_owner == OWN_CPU));
    assign w_host_el = i_host_req && !(w_last && (r_owner == OWN_HOST)) && (!w_last || w_promote);

    assign w_gnt_vid  = w_arb && w_vid_el;
    assign w_gnt_host = w_arb && !w_vid_el && w_host_el && (w_promote || !w_cpu_el);
    assign w_gnt_cpu  = w_arb && !w_vid_el && w_cpu_el && !(w_host_el && w_promote);
    assign w_gnt      = w_gnt_vid || w_gnt_cpu || w_gnt_host;

    // Request fields captured at the grant edge
    always_comb begin
        w_sel_owner = OWN_VID;
        w_sel_addr  = {VID_BASE, i_vid_addr};
        w_sel_we    = 1'b0;
        w_sel_wdata = 16'h0000;
        w_sel_lb_n  = 1'b0;
        w_sel_ub_n  = 1'b0;
        if (w_gnt_cpu) begin
            w_sel_owner = OWN_CPU;
            w_sel_addr  = {3'b000, i_cpu_adr[15:1]};
            w_sel_we    = i_cpu_we;
            w_sel_wdata = i_cpu_byte ? {i_cpu_wdata[7:0], i_cpu_wdata[7:0]} : i_cpu_wdata;
            w_sel_lb_n  = i_cpu_byte &  i_cpu_adr[0];
            w_sel_ub_n  = i_cpu_byte & ~i_cpu_adr[0];
        end else if (w_gnt_host) begin
            w_sel_owner = OWN_HOST;
            w_sel_addr  = i_host_addr;
            w_sel_we    = i_host_we;
            w_sel_wdata = i_host_wdata;
        end
    end

    always_comb begin
        if (!i_host_req || w_gnt_host) begin
            w_starve_nxt = 8'd0;
        end else if (r_starve != STARVE) begin
            w_starve_nxt = r_starve + 8'd1;
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_cyc_nxt        = r_cyc;
        w_we_nxt         = r_we;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_dq_o_nxt   = r_ram_dq_o;
        w_ram_dq_oe_nxt  = r_ram_dq_oe;
        w_ram_oe_n_nxt   = r_ram_oe_n;
        w_ram_we_n_nxt   = r_ram_we_n;
        w_ram_lb_n_nxt   = r_ram_lb_n;
        w_ram_ub_n_nxt   = r_ram_ub_n;
        w_vid_ack_nxt    = 1'b0;
        w_cpu_ack_nxt    = 1'b0;
        w_host_ack_nxt   = 1'b0;
        w_vid_data_nxt   = r_vid_data;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_host_rdata_nxt = r_host_rdata;

        if ((r_state == S_ACCESS) && !w_last) begin
            w_cyc_nxt      = r_cyc + CNT_W'(1);
            // first cycle is address setup; the write strobe covers the rest
            w_ram_we_n_nxt = !r_we;
        end

        if (w_last) begin
            case (r_owner)
                OWN_VID: begin
                    w_vid_ack_nxt  = 1'b1;
                    w_vid_data_nxt = i_ram_dq_i;
                end
                OWN_CPU: begin
                    w_cpu_ack_nxt = 1'b1;
                    if (!r_we) w_cpu_rdata_nxt = i_ram_dq_i;
                end
                default: begin
                    w_host_ack_nxt = 1'b1;
                    if (!r_we) w_host_rdata_nxt = i_ram_dq_i;
                end
            endcase
            w_state_nxt     = S_IDLE;
            w_ram_oe_n_nxt  = 1'b1;
            w_ram_we_n_nxt  = 1'b1;
            w_ram_dq_oe_nxt = 1'b0;
            w_ram_lb_n_nxt  = 1'b1;
            w_ram_ub_n_nxt  = 1'b1;
        end

        if (w_gnt) begin
            w_state_nxt     = S_ACCESS;
            w_owner_nxt     = w_sel_owner;
            w_cyc_nxt       = '0;
            w_we_nxt        = w_sel_we;
            w_ram_addr_nxt  = w_sel_addr;
            w_ram_dq_o_nxt  = w_sel_wdata;
            w_ram_dq_oe_nxt = w_sel_we;
            w_ram_oe_n_nxt  = w_sel_we;
            w_ram_we_n_nxt  = 1'b1;
            w_ram_lb_n_nxt  = w_sel_lb_n;
            w_ram_ub_n_nxt  = w_sel_ub_n;
        end
    end

    always_ff @(posedge i_clk25 or posedge i_reset_in) begin
        if (i_reset_in) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_VID;
            r_cyc        <= '0;
            r_we         <= 1'b0;
            r_starve     <= 8'd0;
            r_ram_addr   <= 18'd0;
            r_ram_dq_o   <= 16'd0;
            r_ram_dq_oe  <= 1'b0;
            r_ram_oe_n   <= 1'b1;
            r_ram_we_n   <= 1'b1;
            r_ram_lb_n   <= 1'b1;
            r_ram_ub_n   <= 1'b1;
            r_vid_ack    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_host_ack   <= 1'b0;
            r_vid_data   <= 16'd0;
            r_cpu_rdata  <= 16'd0;
            r_host_rdata <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_cyc        <= w_cyc_nxt;
            r_we         <= w_we_nxt;
            r_starve     <= w_starve_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_dq_o   <= w_ram_dq_o_nxt;
            r_ram_dq_oe  <= w_ram_dq_oe_nxt;
            r_ram_oe_n   <= w_ram_oe_n_nxt;
            r_ram_we_n   <= w_ram_we_n_nxt;
            r_ram_lb_n   <= w_ram_lb_n_nxt;
            r_ram_ub_n   <= w_ram_ub_n_nxt;
            r_vid_ack    <= w_vid_ack_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_host_ack   <= w_host_ack_nxt;
            r_vid_data   <= w_vid_data_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_host_rdata <= w_host_rdata_nxt;
        end
    end

    assign o_vid_ack    = r_vid_ack;
    assign o_vid_data   = r_vid_data;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_dq_o   = r_ram_dq_o;
    assign o_ram_dq_oe  = r_ram_dq_oe;
    assign o_ram_oe_n   = r_ram_oe_n;
    assign o_ram_we_n   = r_ram_we_n;
    assign o_ram_lb_n   = r_ram_lb_n;
    assign o_ram_ub_n   = r_ram_ub_n;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        i_reset_in;
    logic        i_vid_req;
    logic [12:0] i_vid_addr;
    logic        o_vid_ack;
    logic [15:0] o_vid_data;
    logic        i_cpu_req, i_cpu_we, i_cpu_byte;
    logic [15:0] i_cpu_adr, i_cpu_wdata;
    logic        o_cpu_ack;
    logic [15:0] o_cpu_rdata;
    logic        i_host_req, i_host_we;
    logic [17:0] i_host_addr;
    logic [15:0] i_host_wdata;
    logic        o_host_ack;
    logic [15:0] o_host_rdata;
    logic [17:0] o_ram_addr;
    logic [15:0] o_ram_dq_o;
    logic        o_ram_dq_oe;
    logic [15:0] i_ram_dq_i;
    logic        o_ram_oe_n, o_ram_we_n, o_ram_lb_n, o_ram_ub_n;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    sram_arbiter dut (
        .i_clk25     (clk),
        .i_reset_in  (i_reset_in),
        .i_vid_req   (i_vid_req),
        .i_vid_addr  (i_vid_addr),
        .o_vid_ack   (o_vid_ack),
        .o_vid_data  (o_vid_data),
        .i_cpu_req   (i_cpu_req),
        .i_cpu_we    (i_cpu_we),
        .i_cpu_byte  (i_cpu_byte),
        .i_cpu_adr   (i_cpu_adr),
        .i_cpu_wdata (i_cpu_wdata),
        .o_cpu_ack   (o_cpu_ack),
        .o_cpu_rdata (o_cpu_rdata),
        .i_host_req  (i_host_req),
        .i_host_we   (i_host_we),
        .i_host_addr (i_host_addr),
        .i_host_wdata(i_host_wdata),
        .o_host_ack  (o_host_ack),
        .o_host_rdata(o_host_rdata),
        .o_ram_addr  (o_ram_addr),
        .o_ram_dq_o  (o_ram_dq_o),
        .o_ram_dq_oe (o_ram_dq_oe),
        .i_ram_dq_i  (i_ram_dq_i),
        .o_ram_oe_n  (o_ram_oe_n),
        .o_ram_we_n  (o_ram_we_n),
        .o_ram_lb_n  (o_ram_lb_n),
        .o_ram_ub_n  (o_ram_ub_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bus control as {oe_n, we_n, lb_n, ub_n, dq_oe}
    function automatic logic [4:0] bus_ctl();
        return {o_ram_oe_n, o_ram_we_n, o_ram_lb_n, o_ram_ub_n, o_ram_dq_oe};
    endfunction

    task automatic test_reset();
        i_reset_in = 1'b1;
        i_vid_req = 0; i_vid_addr = '0;
        i_cpu_req = 0; i_cpu_we = 0; i_cpu_byte = 0; i_cpu_adr = '0; i_cpu_wdata = '0;
        i_host_req = 0; i_host_we = 0; i_host_addr = '0; i_host_wdata = '0;
        i_ram_dq_i = '0;
        repeat (2) tick();
        checks++;
        if (bus_ctl() !== 5'b11110) begin
            errors++; $display("FAIL reset_bus_ctl got %b want %b", bus_ctl(), 5'b11110);
        end
        checks++;
        if ({o_ram_addr, o_ram_dq_o} !== 34'd0) begin
            errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", o_ram_addr, o_ram_dq_o);
        end
        checks++;
        if ({o_vid_ack, o_cpu_ack, o_host_ack, o_vid_data, o_cpu_rdata, o_host_rdata} !== 51'd0) begin
            errors++; $display("FAIL reset_acks_rdata got %b%b%b %h %h %h want all 0",
                               o_vid_ack, o_cpu_ack, o_host_ack, o_vid_data, o_cpu_rdata, o_host_rdata);
        end
        @(negedge clk);
        i_reset_in = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        exp_t e;
        i_ram_dq_i = 16'hA5C3;
        i_cpu_adr = 16'o001000; i_cpu_we = 0; i_cpu_byte = 0; i_cpu_req = 1;
        sb_q.push_back('{18'h00100, 16'hA5C3});
        tick();
        checks++;
        if (o_ram_addr !== sb_q[0].addr) begin
            errors++; $display("FAIL cpu_read_addr got %h want %h", o_ram_addr, sb_q[0].addr);
        end
        checks++;
        if (bus_ctl() !== 5'b01000 || o_cpu_ack !== 1'b0) begin
            errors++; $display("FAIL cpu_read_cycle0 got ctl=%b ack=%b want ctl=01000 ack=0", bus_ctl(), o_cpu_ack);
        end
        tick();
        checks++;
        if (o_ram_oe_n !== 1'b0 || o_cpu_ack !== 1'b0) begin
            errors++; $display("FAIL cpu_read_cycle1 got oe_n=%b ack=%b want 0/0", o_ram_oe_n, o_cpu_ack);
        end
        tick();
        e = sb_q.pop_front();
        checks++;
        if (o_cpu_ack !== 1'b1 || o_cpu_rdata !== e.data) begin
            errors++; $display("FAIL cpu_read_ack got ack=%b rdata=%h want 1/%h", o_cpu_ack, o_cpu_rdata, e.data);
        end
        i_cpu_req = 0;
        tick();
        checks++;
        if (o_cpu_ack !== 1'b0 || bus_ctl() !== 5'b11110 || o_ram_addr !== 18'h00100) begin
            errors++; $display("FAIL cpu_read_idle got ack=%b ctl=%b addr=%h want 0/11110/00100",
                               o_cpu_ack, bus_ctl(), o_ram_addr);
        end
    endtask

    task automatic test_cpu_byte_write();
        exp_t e;
        int we_low = 0;
        int got_ack = 0;
        i_cpu_adr = 16'h0401; i_cpu_wdata = 16'h0077; i_cpu_we = 1; i_cpu_byte = 1; i_cpu_req = 1;
        sb_q.push_back('{18'h00200, 16'h7777});
        tick();
        e = sb_q.pop_front();
        checks++;
        if (o_ram_addr !== e.addr || o_ram_dq_o !== e.data) begin
            errors++; $display("FAIL bw_addr_data got %h/%h want %h/%h", o_ram_addr, o_ram_dq_o, e.addr, e.data);
        end
        checks++;
        if (bus_ctl() !== 5'b11101) begin
            errors++; $display("FAIL bw_setup_ctl got %b want 11101", bus_ctl());
        end
        for (int i = 0; i < 4 && got_ack == 0; i++) begin
            tick();
            if (o_ram_we_n === 1'b0) begin
                we_low++;
                if (o_ram_oe_n !== 1'b1 || o_ram_dq_oe !== 1'b1) begin
                    checks++; errors++;
                    $display("FAIL bw_strobe got oe_n=%b dq_oe=%b want 1/1", o_ram_oe_n, o_ram_dq_oe);
                end
            end
            if (o_cpu_ack === 1'b1) got_ack = i + 1;
        end
        i_cpu_req = 0;
        checks++;
        if (we_low != 1 || got_ack != 2) begin
            errors++; $display("FAIL bw_timing got we_low=%0d ack_at=%0d want 1/2", we_low, got_ack);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        i_cpu_adr = 16'h0010; i_cpu_wdata = 16'h1234; i_cpu_we = 1; i_cpu_byte = 0; i_cpu_req = 1;
        tick();
        tick();
        checks++;
        if (o_ram_we_n !== 1'b0 || o_ram_dq_oe !== 1'b1) begin
            errors++; $display("FAIL rst_pre_strobe got we_n=%b dq_oe=%b want 0/1", o_ram_we_n, o_ram_dq_oe);
        end
        #5 i_reset_in = 1'b1;
        #1;
        checks++;
        if (o_ram_we_n !== 1'b1 || o_ram_dq_oe !== 1'b0 || o_ram_oe_n !== 1'b1) begin
            errors++; $display("FAIL rst_async_abort got we_n=%b dq_oe=%b oe_n=%b want 1/0/1",
                               o_ram_we_n, o_ram_dq_oe, o_ram_oe_n);
        end
        i_cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_cpu_ack === 1'b1) acks++;
        end
        @(negedge clk);
        i_reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_cpu_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || bus_ctl() !== 5'b11110) begin
            errors++; $display("FAIL rst_no_ack_idle got acks=%0d ctl=%b want 0/11110", acks, bus_ctl());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        i_ram_dq_i = 16'hBEEF;
        i_vid_addr = 13'h0005; i_vid_req = 1;
        i_cpu_adr = 16'h0010; i_cpu_we = 0; i_cpu_byte = 0; i_cpu_req = 1;
        sb_q.push_back('{18'h02005, 16'hBEEF});
        sb_q.push_back('{18'h00008, 16'h1357});
        tick();
        checks++;
        if (o_ram_addr !== sb_q[0].addr || o_ram_oe_n !== 1'b0) begin
            errors++; $display("FAIL b2b_vid_first got addr=%h oe_n=%b want %h/0", o_ram_addr, o_ram_oe_n, sb_q[0].addr);
        end
        tick();
        tick();
        e = sb_q.pop_front();
        checks++;
        if (o_vid_ack !== 1'b1 || o_vid_data !== e.data) begin
            errors++; $display("FAIL b2b_vid_ack got ack=%b data=%h want 1/%h", o_vid_ack, o_vid_data, e.data);
        end
        checks++;
        if (o_ram_addr !== sb_q[0].addr || o_ram_oe_n !== 1'b0 || o_cpu_ack !== 1'b0) begin
            errors++; $display("FAIL b2b_cpu_no_gap got addr=%h oe_n=%b cpu_ack=%b want %h/0/0",
                               o_ram_addr, o_ram_oe_n, o_cpu_ack, sb_q[0].addr);
        end
        i_vid_req = 0;
        i_ram_dq_i = 16'h1357;
        tick();
        tick();
        e = sb_q.pop_front();
        checks++;
        if (o_cpu_ack !== 1'b1 || o_cpu_rdata !== e.data || o_vid_ack !== 1'b0) begin
            errors++; $display("FAIL b2b_cpu_ack got ack=%b rdata=%h vid_ack=%b want 1/%h/0",
                               o_cpu_ack, o_cpu_rdata, o_vid_ack, e.data);
        end
        i_cpu_req = 0;
        repeat (2) tick();
    endtask

    task automatic test_host_starve();
        exp_t e;
        int gnt = -1;
        int acks = 0;
        int got = 0;
        i_ram_dq_i = 16'h4242;
        i_cpu_adr = 16'h0020; i_cpu_we = 0; i_cpu_byte = 0; i_cpu_req = 1;
        i_host_addr = 18'h3ABCD; i_host_we = 0; i_host_req = 1;
        sb_q.push_back('{18'h3ABCD, 16'h4242});
        for (int i = 0; i < 80 && gnt < 0; i++) begin
            tick();
            if (o_cpu_ack === 1'b1) acks++;
            if (o_ram_addr === sb_q[0].addr && o_ram_oe_n === 1'b0) gnt = i;
        end
        checks++;
        if (gnt != 32 || acks != 11) begin
            errors++; $display("FAIL starve_first got grant_edge=%0d cpu_acks=%0d want 32/11", gnt, acks);
        end
        for (int i = 0; i < 6 && got == 0; i++) begin
            tick();
            if (o_host_ack === 1'b1) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (got != 1 || o_host_rdata !== e.data) begin
            errors++; $display("FAIL starve_host_ack got ack=%0d rdata=%h want 1/%h", got, o_host_rdata, e.data);
        end
        i_host_req = 0;
        repeat (3) tick();
        i_ram_dq_i = 16'h5A5A;
        i_host_req = 1;
        sb_q.push_back('{18'h3ABCD, 16'h5A5A});
        gnt = -1;
        for (int i = 0; i < 80 && gnt < 0; i++) begin
            tick();
            if (o_ram_addr === sb_q[0].addr && o_ram_oe_n === 1'b0) gnt = i;
        end
        checks++;
        if (gnt < 32 || gnt > 33) begin
            errors++; $display("FAIL starve_second got grant_edge=%0d want 32..33", gnt);
        end
        got = 0;
        for (int i = 0; i < 6 && got == 0; i++) begin
            tick();
            if (o_host_ack === 1'b1) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (got != 1 || o_host_rdata !== e.data) begin
            errors++; $display("FAIL starve_host_ack2 got ack=%0d rdata=%h want 1/%h", got, o_host_rdata, e.data);
        end
        i_host_req = 0;
        i_cpu_req = 0;
        repeat (4) tick();
        checks++;
        if (bus_ctl() !== 5'b11110 || sb_q.size() != 0) begin
            errors++; $display("FAIL final_idle got ctl=%b pending=%0d want 11110/0", bus_ctl(), sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_byte_write();
        test_reset_mid_write();
        test_back_to_back();
        test_host_starve();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
